// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit: multi-cycle restoring divider producing quotient and
// remainder of i_dividend / i_divisor. It has valid/ready handshakes on both
// the operand side and the result side.
// Optional feature macro: SEQ_DIV_SIGNED_EN. When it is defined, an i_signed
// port is added and two's complement division is supported. When it is not
// defined, the divider is unsigned only and o_overflow is tied to 0.
module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             i_signed,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero,
    output logic             o_overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state, w_nxtState;
    logic [CW-1:0]    r_count, w_nxtCount;
    logic [WIDTH-1:0] r_rem, w_nxtRem;
    logic [WIDTH-1:0] r_dq, w_nxtDq;
    logic [WIDTH-1:0] r_divisor, w_nxtDivisor;
    logic             r_negQ, w_nxtNegQ;
    logic             r_negR, w_nxtNegR;
    logic             w_nxtReady, w_nxtValid, w_nxtDbz;
    logic [WIDTH-1:0] w_nxtQuot, w_nxtRemOut;

    logic             w_signed;
    logic             w_dvdNeg, w_dvsNeg;
    logic [WIDTH-1:0] w_dvdMag, w_dvsMag;
    logic [WIDTH:0]   w_shift, w_trial;
    logic             w_qBit;
    logic [WIDTH-1:0] w_iterRem, w_iterDq;
    logic             w_isLast;

`ifdef SEQ_DIV_SIGNED_EN
    logic r_ovfPend, w_nxtOvfPend;
    logic w_nxtOvf;
    logic w_minOverNeg1;
    assign w_signed      = i_signed;
    assign w_minOverNeg1 = i_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                    && (i_divisor == {WIDTH{1'b1}});
`else
    assign w_signed   = 1'b0;
    assign o_overflow = 1'b0;
`endif

    // Operand magnitudes: the core always divides unsigned magnitudes.
    assign w_dvdNeg = w_signed & i_dividend[WIDTH-1];
    assign w_dvsNeg = w_signed & i_divisor[WIDTH-1];
    assign w_dvdMag = w_dvdNeg ? ({WIDTH{1'b0}} - i_dividend) : i_dividend;
    assign w_dvsMag = w_dvsNeg ? ({WIDTH{1'b0}} - i_divisor) : i_divisor;

    // One restoring step. r_dq starts out holding the dividend and
    // gradually fills with quotient bits from the LSB end.
    assign w_shift   = {r_rem, r_dq[WIDTH-1]};
    assign w_trial   = w_shift + (~{1'b0, r_divisor}) + {{WIDTH{1'b0}}, 1'b1};
    assign w_qBit    = ~w_trial[WIDTH];
    assign w_iterRem = w_qBit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_iterDq  = {r_dq[WIDTH-2:0], w_qBit};
    assign w_isLast  = (r_count == CW'(WIDTH-1));

    // Next-state and next-register values for the handshake FSM and datapath
    always_comb begin
        w_nxtState   = r_state;
        w_nxtCount   = r_count;
        w_nxtRem     = r_rem;
        w_nxtDq      = r_dq;
        w_nxtDivisor = r_divisor;
        w_nxtNegQ    = r_negQ;
        w_nxtNegR    = r_negR;
        w_nxtReady   = o_ready;
        w_nxtValid   = o_valid;
        w_nxtQuot    = o_quotient;
        w_nxtRemOut  = o_remainder;
        w_nxtDbz     = o_div_by_zero;
`ifdef SEQ_DIV_SIGNED_EN
        w_nxtOvfPend = r_ovfPend;
        w_nxtOvf     = o_overflow;
`endif
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_nxtReady   = 1'b0;
                    w_nxtRem     = '0;
                    w_nxtDq      = w_dvdMag;
                    w_nxtDivisor = w_dvsMag;
                    w_nxtCount   = '0;
                    w_nxtNegQ    = w_dvdNeg ^ w_dvsNeg;
                    w_nxtNegR    = w_dvdNeg;
`ifdef SEQ_DIV_SIGNED_EN
                    w_nxtOvfPend = w_minOverNeg1;
`endif
                    if (i_divisor == '0) begin
                        w_nxtState  = DONE;
                        w_nxtValid  = 1'b1;
                        w_nxtQuot   = {WIDTH{1'b1}};
                        w_nxtRemOut = i_dividend;
                        w_nxtDbz    = 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
                        w_nxtOvf    = 1'b0;
`endif
                    end else begin
                        w_nxtState = CALC;
                    end
                end
            end
            CALC: begin
                w_nxtRem   = w_iterRem;
                w_nxtDq    = w_iterDq;
                w_nxtCount = r_count + 1'b1;
                if (w_isLast) begin
                    w_nxtState  = DONE;
                    w_nxtValid  = 1'b1;
                    w_nxtQuot   = r_negQ ? ({WIDTH{1'b0}} - w_iterDq) : w_iterDq;
                    w_nxtRemOut = r_negR ? ({WIDTH{1'b0}} - w_iterRem) : w_iterRem;
                    w_nxtDbz    = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                    w_nxtOvf    = r_ovfPend;
`endif
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_nxtState = IDLE;
                    w_nxtValid = 1'b0;
                    w_nxtReady = 1'b1;
                end
            end
            default: begin
                w_nxtState = IDLE;
                w_nxtValid = 1'b0;
                w_nxtReady = 1'b1;
            end
        endcase
    end

    // State and output registers, with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_rem         <= '0;
            r_dq          <= '0;
            r_divisor     <= '0;
            r_negQ        <= 1'b0;
            r_negR        <= 1'b0;
            o_ready       <= 1'b1;
            o_valid       <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_ovfPend     <= 1'b0;
            o_overflow    <= 1'b0;
`endif
        end else begin
            r_state       <= w_nxtState;
            r_count       <= w_nxtCount;
            r_rem         <= w_nxtRem;
            r_dq          <= w_nxtDq;
            r_divisor     <= w_nxtDivisor;
            r_negQ        <= w_nxtNegQ;
            r_negR        <= w_nxtNegR;
            o_ready       <= w_nxtReady;
            o_valid       <= w_nxtValid;
            o_quotient    <= w_nxtQuot;
            o_remainder   <= w_nxtRemOut;
            o_div_by_zero <= w_nxtDbz;
`ifdef SEQ_DIV_SIGNED_EN
            r_ovfPend     <= w_nxtOvfPend;
            o_overflow    <= w_nxtOvf;
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// tb_seq_divider_8bit: directed self-checking bench for seq_divider_8bit.
// When SEQ_DIV_SIGNED_EN is defined, the signed cases are also exercised.
module tb_seq_divider_8bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       in_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       dbz;
    logic       ovf;
`ifdef SEQ_DIV_SIGNED_EN
    logic       sgn;
`endif

    int nCompared;
    int nMismatched;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (in_valid),
        .o_ready       (out_ready),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
`ifdef SEQ_DIV_SIGNED_EN
        .i_signed      (sgn),
`endif
        .o_valid       (out_valid),
        .i_ready       (in_ready),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (dbz),
        .o_overflow    (ovf)
    );

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog timer, so that a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge, then sample and drive 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for a single accept edge
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Consume the pending result
    task automatic release_result();
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        nCompared++; if (out_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b want 1", out_ready); end
        nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        nCompared++; if ({quotient, remainder} !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_qr: got %h/%h want 00/00", quotient, remainder); end
        nCompared++; if ({dbz, ovf} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_flags: got dbz=%b ovf=%b want 0/0", dbz, ovf); end
    endtask

    task automatic test_basic();
        start_op(8'd100, 8'd7);
        nCompared++; if (out_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_ready_drop: got %b want 0", out_ready); end
        repeat (7) tick();
        nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_early_valid: got %b want 0 after 7 edges", out_valid); end
        tick();
        nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_latency: got valid=%b want 1 after 8 edges", out_valid); end
        nCompared++; if (quotient !== 8'd14) begin nMismatched++; $display("[TB] FAIL basic_q: got %0d want 14", quotient); end
        nCompared++; if (remainder !== 8'd2) begin nMismatched++; $display("[TB] FAIL basic_r: got %0d want 2", remainder); end
        nCompared++; if ({dbz, ovf} !== 2'b00) begin nMismatched++; $display("[TB] FAIL basic_flags: got dbz=%b ovf=%b want 0/0", dbz, ovf); end
        release_result();
        nCompared++; if ({out_valid, out_ready} !== 2'b01) begin nMismatched++; $display("[TB] FAIL basic_release: got valid=%b ready=%b want 0/1", out_valid, out_ready); end
    endtask

    task automatic test_boundaries();
        start_op(8'd255, 8'd1);
        repeat (8) tick();
        nCompared++; if ({out_valid, quotient, remainder} !== {1'b1, 8'd255, 8'd0}) begin nMismatched++; $display("[TB] FAIL div_by_one: got v=%b q=%0d r=%0d want 1/255/0", out_valid, quotient, remainder); end
        release_result();
        start_op(8'd200, 8'd250);
        repeat (8) tick();
        nCompared++; if ({out_valid, quotient, remainder} !== {1'b1, 8'd0, 8'd200}) begin nMismatched++; $display("[TB] FAIL small_dividend: got v=%b q=%0d r=%0d want 1/0/200", out_valid, quotient, remainder); end
        release_result();
    endtask

    task automatic test_div_by_zero();
        start_op(8'd37, 8'd0);
        tick();
        nCompared++; if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL dbz_latency: got valid=%b want 1", out_valid); end
        nCompared++; if ({quotient, remainder} !== {8'hFF, 8'd37}) begin nMismatched++; $display("[TB] FAIL dbz_qr: got q=%h r=%0d want FF/37", quotient, remainder); end
        nCompared++; if ({dbz, ovf} !== 2'b10) begin nMismatched++; $display("[TB] FAIL dbz_flags: got dbz=%b ovf=%b want 1/0", dbz, ovf); end
        release_result();
    endtask

    task automatic test_back_to_back();
        start_op(8'd50, 8'd6);
        repeat (8) tick();
        dividend = 8'd9;
        divisor  = 8'd2;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            nCompared++; if ({out_valid, out_ready, quotient, remainder, dbz} !== {1'b1, 1'b0, 8'd8, 8'd2, 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL backpressure_hold[%0d]: got v=%b rdy=%b q=%0d r=%0d dbz=%b want 1/0/8/2/0", k, out_valid, out_ready, quotient, remainder, dbz);
            end
        end
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        nCompared++; if ({out_valid, out_ready} !== 2'b01) begin nMismatched++; $display("[TB] FAIL handoff_edge: got valid=%b ready=%b want 0/1", out_valid, out_ready); end
        tick();
        in_valid = 1'b0;
        nCompared++; if (out_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL next_accept: got ready=%b want 0", out_ready); end
        repeat (8) tick();
        nCompared++; if ({out_valid, quotient, remainder} !== {1'b1, 8'd4, 8'd1}) begin nMismatched++; $display("[TB] FAIL second_op: got v=%b q=%0d r=%0d want 1/4/1", out_valid, quotient, remainder); end
        release_result();
    endtask

    task automatic test_reset_midcalc();
        start_op(8'd200, 8'd3);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nCompared++; if ({out_valid, out_ready} !== 2'b01) begin nMismatched++; $display("[TB] FAIL midreset_hs: got valid=%b ready=%b want 0/1", out_valid, out_ready); end
        nCompared++; if ({quotient, remainder, dbz, ovf} !== 18'd0) begin nMismatched++; $display("[TB] FAIL midreset_outs: got q=%0d r=%0d dbz=%b ovf=%b want all 0", quotient, remainder, dbz, ovf); end
        repeat (10) tick();
        nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_dropped: got valid=%b want 0", out_valid); end
        start_op(8'd9, 8'd3);
        repeat (8) tick();
        nCompared++; if ({out_valid, quotient, remainder} !== {1'b1, 8'd3, 8'd0}) begin nMismatched++; $display("[TB] FAIL after_reset_op: got v=%b q=%0d r=%0d want 1/3/0", out_valid, quotient, remainder); end
        release_result();
    endtask

`ifdef SEQ_DIV_SIGNED_EN
    task automatic test_signed();
        sgn = 1'b1;
        start_op(8'h9C, 8'd7);
        sgn = 1'b0;
        repeat (8) tick();
        nCompared++; if ({out_valid, quotient, remainder, ovf} !== {1'b1, 8'hF2, 8'hFE, 1'b0}) begin nMismatched++; $display("[TB] FAIL signed_neg: got v=%b q=%h r=%h ovf=%b want 1/F2/FE/0", out_valid, quotient, remainder, ovf); end
        release_result();
        tick();
        sgn = 1'b1;
        start_op(8'h80, 8'hFF);
        sgn = 1'b0;
        repeat (8) tick();
        nCompared++; if ({out_valid, quotient, remainder, ovf} !== {1'b1, 8'h80, 8'h00, 1'b1}) begin nMismatched++; $display("[TB] FAIL signed_ovf: got v=%b q=%h r=%h ovf=%b want 1/80/00/1", out_valid, quotient, remainder, ovf); end
        release_result();
    endtask
`endif

    // Test sequence
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_ready    = 1'b0;
        dividend    = '0;
        divisor     = '0;
`ifdef SEQ_DIV_SIGNED_EN
        sgn         = 1'b0;
`endif
        #2;
        test_reset();
        test_basic();
        tick();
        test_boundaries();
        tick();
        test_div_by_zero();
        tick();
        test_back_to_back();
        tick();
        test_reset_midcalc();
`ifdef SEQ_DIV_SIGNED_EN
        tick();
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
